// File: rtl/fetch_stage_if.sv
// Fetch-stage bundle: instruction-memory bus, control from decode/execute, and the IF/ID register.
// The slave modport is the fetch stage; the master side drives control and the memory word.
interface fetch_stage_if #(
   parameter int CNT_W = 16
);
   logic             stall;
   logic             redirect_valid;
   logic [31:0]      redirect_pc;
   logic [31:0]      pc_ir;
   logic [31:0]      ir_in;
   logic [31:0]      if_id_ir;
   logic [31:0]      if_id_pc;
   logic             if_id_valid;
   logic             halted;
   logic [CNT_W-1:0] fetch_count;

   modport master (
      output stall, redirect_valid, redirect_pc, ir_in,
      input  pc_ir, if_id_ir, if_id_pc, if_id_valid, halted, fetch_count
   );

   modport slave (
      input  stall, redirect_valid, redirect_pc, ir_in,
      output pc_ir, if_id_ir, if_id_pc, if_id_valid, halted, fetch_count
   );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the word-indexed PC, fills IF/ID, handles stall/redirect,
// and parks itself in HALT after a run of all-zero instruction words.
module fetch_stage #(
   parameter int          IMEM_DEPTH    = 1024,
   parameter logic [31:0] RESET_PC      = 32'd0,
   parameter int          HALT_ZERO_RUN = 4,
   parameter int          CNT_W         = 16
) (
   input logic          clk,
   input logic          rst_n,
   fetch_stage_if.slave bus
);
   localparam int PC_W = $clog2(IMEM_DEPTH);
   localparam int ZR_W = $clog2(HALT_ZERO_RUN + 1);
   localparam logic [31:0] NOP = 32'h00000013;

   typedef enum logic {RUN, HALT} state_t;

   state_t           state;
   logic [PC_W-1:0]  pc;
   logic [ZR_W-1:0]  zero_run;
   logic [ZR_W-1:0]  zero_run_inc;
   logic [31:0]      pc_ext;
   logic [31:0]      if_id_ir;
   logic [31:0]      if_id_pc;
   logic             if_id_valid;
   logic             halted;
   logic [CNT_W-1:0] fetch_count;
   logic             unused_redirect_hi;

   assign pc_ext       = {{(32-PC_W){1'b0}}, pc};
   assign zero_run_inc = zero_run + 1'b1;

   // Target bits above the memory index are dropped, giving the modulo wrap.
   assign unused_redirect_hi = ^bus.redirect_pc[31:PC_W];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= RUN;
         halted      <= 1'b0;
         pc          <= RESET_PC[PC_W-1:0];
         zero_run    <= '0;
         if_id_ir    <= NOP;
         if_id_pc    <= 32'd0;
         if_id_valid <= 1'b0;
         fetch_count <= '0;
      end else if (bus.redirect_valid) begin
         state       <= RUN;
         halted      <= 1'b0;
         pc          <= bus.redirect_pc[PC_W-1:0];
         zero_run    <= '0;
         if_id_ir    <= NOP;
         if_id_valid <= 1'b0;
      end else if (state == HALT || bus.stall) begin
         state <= state;
      end else if (bus.ir_in != 32'd0) begin
         if_id_ir    <= bus.ir_in;
         if_id_pc    <= pc_ext;
         if_id_valid <= 1'b1;
         pc          <= pc + 1'b1;
         zero_run    <= '0;
         if (fetch_count != {CNT_W{1'b1}}) begin
            fetch_count <= fetch_count + 1'b1;
         end
      end else begin
         // Zero word: insert a bubble; on the last one of the run, stop with PC on it.
         if_id_ir    <= NOP;
         if_id_valid <= 1'b0;
         zero_run    <= zero_run_inc;
         if (zero_run_inc == ZR_W'(HALT_ZERO_RUN)) begin
            state  <= HALT;
            halted <= 1'b1;
         end else begin
            pc <= pc + 1'b1;
         end
      end
   end

   assign bus.pc_ir       = pc_ext;
   assign bus.if_id_ir    = if_id_ir;
   assign bus.if_id_pc    = if_id_pc;
   assign bus.if_id_valid = if_id_valid;
   assign bus.halted      = halted;
   assign bus.fetch_count = fetch_count;
endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: a reference model pushes expected IF state per edge
// into a scoreboard queue, popped and compared one cycle later.
module tb_fetch_stage;
   localparam logic [31:0] NOP = 32'h00000013;
   localparam logic [31:0] W0  = 32'h001383B3;
   localparam logic [31:0] W1  = 32'hFE719FE3;

   typedef struct {
      logic [31:0] pc_ir;
      logic [31:0] ir;
      logic [31:0] ipc;
      logic        valid;
      logic        halted;
      logic [31:0] cnt;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [31:0] mem [0:1023];
   exp_t        exp_q [$];
   int          checks = 0;
   int          failures = 0;

   int          m_pc, m_zr, m_cnt;
   logic        m_halt, m_valid;
   logic [31:0] m_ir, m_ipc;

   fetch_stage_if #(.CNT_W(16)) bus ();

   fetch_stage #(
      .IMEM_DEPTH(1024), .RESET_PC(32'd0), .HALT_ZERO_RUN(4), .CNT_W(16)
   ) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus)
   );

   always #5 clk = ~clk;

   assign bus.ir_in = mem[bus.pc_ir[9:0]];

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: actual %h, required %h", tag, actual, expected);
      end
   endtask

   task automatic resetModel();
      m_pc = 0; m_zr = 0; m_cnt = 0; m_halt = 1'b0;
      m_valid = 1'b0; m_ir = NOP; m_ipc = 32'd0;
   endtask

   task automatic applyStimulus(input logic st, input logic rv, input logic [31:0] rpc);
      exp_t        e;
      logic [31:0] word;
      word = mem[m_pc];
      if (rv) begin
         m_pc = int'(rpc % 1024); m_ir = NOP; m_valid = 1'b0; m_halt = 1'b0; m_zr = 0;
      end else if (!m_halt && !st) begin
         if (word != 32'd0) begin
            m_ir = word; m_ipc = m_pc; m_valid = 1'b1; m_pc = (m_pc + 1) % 1024; m_zr = 0;
            if (m_cnt < 65535) m_cnt++;
         end else begin
            m_ir = NOP; m_valid = 1'b0; m_zr++;
            if (m_zr == 4) m_halt = 1'b1;
            else m_pc = (m_pc + 1) % 1024;
         end
      end
      e.pc_ir = m_pc; e.ir = m_ir; e.ipc = m_ipc; e.valid = m_valid;
      e.halted = m_halt; e.cnt = m_cnt;
      exp_q.push_back(e);
      bus.stall = st; bus.redirect_valid = rv; bus.redirect_pc = rpc;
      @(posedge clk);
      #1;
      bus.stall = 1'b0; bus.redirect_valid = 1'b0;
      e = exp_q.pop_front();
      checkOutput("pc_ir", bus.pc_ir, e.pc_ir);
      checkOutput("if_id_ir", bus.if_id_ir, e.ir);
      checkOutput("if_id_valid", {31'd0, bus.if_id_valid}, {31'd0, e.valid});
      checkOutput("halted", {31'd0, bus.halted}, {31'd0, e.halted});
      checkOutput("fetch_count", {16'd0, bus.fetch_count}, e.cnt);
      if (e.valid) checkOutput("if_id_pc", bus.if_id_pc, e.ipc);
   endtask

   task automatic checkResetValues(input string tag);
      checkOutput({tag, "_pc_ir"}, bus.pc_ir, 32'd0);
      checkOutput({tag, "_ir"}, bus.if_id_ir, NOP);
      checkOutput({tag, "_ipc"}, bus.if_id_pc, 32'd0);
      checkOutput({tag, "_valid"}, {31'd0, bus.if_id_valid}, 32'd0);
      checkOutput({tag, "_halted"}, {31'd0, bus.halted}, 32'd0);
      checkOutput({tag, "_count"}, {16'd0, bus.fetch_count}, 32'd0);
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
      mem[0]    = W0;
      mem[1]    = W1;
      mem[1023] = 32'h00100093;
      bus.stall = 1'b0; bus.redirect_valid = 1'b0; bus.redirect_pc = 32'd0;
      resetModel();

      #2 rst_n = 1'b0;
      #1 checkResetValues("async_rst");
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      checkResetValues("reset");

      applyStimulus(1'b0, 1'b0, 32'd0);
      checkOutput("edge1_ir", bus.if_id_ir, W0);
      checkOutput("edge1_pc_ir", bus.pc_ir, 32'd1);
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 32'd0);
      checkOutput("stall_pc_ir", bus.pc_ir, 32'd1);
      applyStimulus(1'b0, 1'b0, 32'd0);
      checkOutput("edge2_ir", bus.if_id_ir, W1);
      checkOutput("edge2_count", {16'd0, bus.fetch_count}, 32'd2);
      checkOutput("resume_pc_ir", bus.pc_ir, 32'd2);

      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 32'd0);
      checkOutput("pre_redirect_pc", bus.pc_ir, 32'd5);
      applyStimulus(1'b1, 1'b1, 32'd0);
      checkOutput("flush_ir", bus.if_id_ir, NOP);
      applyStimulus(1'b0, 1'b0, 32'd0);
      checkOutput("refetch_ir", bus.if_id_ir, W0);

      applyStimulus(1'b0, 1'b0, 32'd0);
      for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 32'd0);
      checkOutput("halt_flag", {31'd0, bus.halted}, 32'd1);
      checkOutput("halt_pc", bus.pc_ir, 32'd5);
      applyStimulus(1'b0, 1'b0, 32'd0);
      applyStimulus(1'b1, 1'b0, 32'd0);
      checkOutput("halt_hold_pc", bus.pc_ir, 32'd5);
      applyStimulus(1'b0, 1'b1, 32'd0);
      applyStimulus(1'b0, 1'b0, 32'd0);
      checkOutput("unhalt_ir", bus.if_id_ir, W0);

      applyStimulus(1'b0, 1'b1, 32'd1023);
      applyStimulus(1'b0, 1'b0, 32'd0);
      checkOutput("wrap_pc", bus.pc_ir, 32'd0);
      checkOutput("wrap_ipc", bus.if_id_pc, 32'd1023);
      applyStimulus(1'b0, 1'b1, 32'd1030);
      checkOutput("redirect_mod_pc", bus.pc_ir, 32'd6);

      applyStimulus(1'b0, 1'b1, 32'd0);
      applyStimulus(1'b0, 1'b0, 32'd0);
      checkOutput("pre_reset_valid", {31'd0, bus.if_id_valid}, 32'd1);
      #3 rst_n = 1'b0;
      #1 checkResetValues("mid_reset");
      resetModel();
      @(negedge clk);
      rst_n = 1'b1;
      applyStimulus(1'b0, 1'b0, 32'd0);
      checkOutput("post_reset_ir", bus.if_id_ir, W0);
      checkOutput("post_reset_count", {16'd0, bus.fetch_count}, 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end
endmodule
